// File: rtl/counter_load_scheduler.sv
// Round-robin arbiter that lends one external 8-bit loadable up counter to NREQ requesters,
// loading each winner's start value and pulsing done when the counter reaches its limit.
module counter_load_scheduler #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [8*NREQ-1:0] req_start,
    input  logic [8*NREQ-1:0] req_limit,
    input  logic [7:0]        cnt_count,
    output logic              cnt_load,
    output logic [7:0]        cnt_data,
    output logic [NREQ-1:0]   grant,
    output logic [NREQ-1:0]   done,
    output logic              busy,
    output logic [IDW-1:0]    active_id
);

    typedef enum logic [1:0] {StIdle, StLoad, StRun, StDone} state_e;

    localparam logic [IDW:0] NReqW = (IDW+1)'(NREQ);

    state_e          state_q, state_d;
    logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]  idx_q, idx_d;
    logic [7:0]      limit_q, limit_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [NREQ-1:0] done_q, done_d;
    logic            cnt_load_q, cnt_load_d;
    logic [7:0]      cnt_data_q, cnt_data_d;
    logic            busy_q, busy_d;
    logic [IDW-1:0]  active_id_q, active_id_d;

    logic            pick_valid;
    logic [IDW-1:0]  pick_idx;
    logic [7:0]      pick_start;
    logic [7:0]      pick_limit;
    logic [IDW:0]    sum;
    logic [IDW-1:0]  cand;
    logic [IDW-1:0]  nxt_ptr;

    function automatic logic [NREQ-1:0] onehot(input logic [IDW-1:0] i);
        logic [NREQ-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // Scan rr_ptr, rr_ptr+1, ... (mod NREQ) and take the first active request.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        pick_start = '0;
        pick_limit = '0;
        sum        = '0;
        cand       = '0;
        for (int k = 0; k < NREQ; k++) begin
            sum = {1'b0, rr_ptr_q} + (IDW+1)'(k);
            if (sum >= NReqW) begin
                sum = sum - NReqW;
            end
            cand = sum[IDW-1:0];
            for (int i = 0; i < NREQ; i++) begin
                if (!pick_valid && req[i] && cand == IDW'(i)) begin
                    pick_valid = 1'b1;
                    pick_idx   = cand;
                    pick_start = req_start[8*i +: 8];
                    pick_limit = req_limit[8*i +: 8];
                end
            end
        end
    end

    assign nxt_ptr = (idx_q == IDW'(NREQ - 1)) ? '0 : idx_q + IDW'(1);

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        idx_d       = idx_q;
        limit_d     = limit_q;
        grant_d     = grant_q;
        done_d      = '0;
        cnt_load_d  = 1'b0;
        cnt_data_d  = cnt_data_q;
        busy_d      = busy_q;
        active_id_d = active_id_q;
        unique case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    state_d     = StLoad;
                    idx_d       = pick_idx;
                    limit_d     = pick_limit;
                    grant_d     = onehot(pick_idx);
                    cnt_load_d  = 1'b1;
                    cnt_data_d  = pick_start;
                    busy_d      = 1'b1;
                    active_id_d = pick_idx;
                end
            end
            StLoad: begin
                state_d = StRun;
            end
            StRun: begin
                // A dropped request wins over a same-cycle limit match: no done pulse.
                if (!req[idx_q]) begin
                    state_d     = StIdle;
                    rr_ptr_d    = nxt_ptr;
                    grant_d     = '0;
                    busy_d      = 1'b0;
                    active_id_d = '0;
                end else if (cnt_count == limit_q) begin
                    state_d = StDone;
                    done_d  = grant_q;
                end
            end
            StDone: begin
                state_d     = StIdle;
                rr_ptr_d    = nxt_ptr;
                grant_d     = '0;
                busy_d      = 1'b0;
                active_id_d = '0;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            rr_ptr_q    <= '0;
            idx_q       <= '0;
            limit_q     <= '0;
            grant_q     <= '0;
            done_q      <= '0;
            cnt_load_q  <= 1'b0;
            cnt_data_q  <= '0;
            busy_q      <= 1'b0;
            active_id_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            idx_q       <= idx_d;
            limit_q     <= limit_d;
            grant_q     <= grant_d;
            done_q      <= done_d;
            cnt_load_q  <= cnt_load_d;
            cnt_data_q  <= cnt_data_d;
            busy_q      <= busy_d;
            active_id_q <= active_id_d;
        end
    end

    assign cnt_load  = cnt_load_q;
    assign cnt_data  = cnt_data_q;
    assign grant     = grant_q;
    assign done      = done_q;
    assign busy      = busy_q;
    assign active_id = active_id_q;

endmodule

// File: tb/tb_counter_load_scheduler.sv
// Scoreboard bench for counter_load_scheduler: directed requests push expected services,
// a negedge monitor pops them on each counter load and checks data, owner and done latency.
module tb_counter_load_scheduler;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req;
    logic [8*NREQ-1:0] req_start;
    logic [8*NREQ-1:0] req_limit;
    logic [7:0]        cnt_count = 8'd0;
    logic              cnt_load;
    logic [7:0]        cnt_data;
    logic [NREQ-1:0]   grant;
    logic [NREQ-1:0]   done;
    logic              busy;
    logic [IDW-1:0]    active_id;

    counter_load_scheduler #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_start (req_start),
        .req_limit (req_limit),
        .cnt_count (cnt_count),
        .cnt_load  (cnt_load),
        .cnt_data  (cnt_data),
        .grant     (grant),
        .done      (done),
        .busy      (busy),
        .active_id (active_id)
    );

    always #5 clk = ~clk;

    // The shared counter itself.
    always @(posedge clk) cnt_count <= cnt_load ? cnt_data : cnt_count + 8'd1;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int       id;
        int       data;
        int       lat;
        bit       abort;
        bit       b2b;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int id, input int data, input int lat, input bit abort,
                        input bit b2b);
        exp_t e;
        e.id    = id;
        e.data  = data;
        e.lat   = lat;
        e.abort = abort;
        e.b2b   = b2b;
        sb.push_back(e);
    endtask

    task automatic set_vals(input int id, input int s, input int l);
        req_start[8*id +: 8] = 8'(s);
        req_limit[8*id +: 8] = 8'(l);
    endtask

    task automatic wait_done(input int id);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done[id] && n < 400);
        if (!done[id]) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_done%0d: no done pulse within %0d cycles", id, n);
        end
    endtask

    // Monitor
    exp_t            cur;
    bit              cur_valid     = 1'b0;
    bit              saw_done      = 1'b0;
    bit              prev_load     = 1'b0;
    int              load_cyc      = 0;
    int              last_done_cyc = -100;
    logic [NREQ-1:0] prev_grant    = '0;

    always @(negedge clk) begin
        if (!rst) begin
            cur_valid  = 1'b0;
            prev_grant = '0;
            prev_load  = 1'b0;
        end else begin
            if (cnt_load) begin
                check("load_single_cycle", int'(prev_load), 0);
                if (sb.size() == 0) begin
                    check("unexpected_load_sb_size", 0, 1);
                end else begin
                    cur       = sb.pop_front();
                    cur_valid = 1'b1;
                    saw_done  = 1'b0;
                    load_cyc  = cyc;
                    check("load_data", int'(cnt_data), cur.data);
                    check("load_grant", int'(grant), 1 << cur.id);
                    check("load_active_id", int'(active_id), cur.id);
                    check("load_busy", int'(busy), 1);
                    if (cur.b2b) check("idle_gap", load_cyc - last_done_cyc, 2);
                end
            end
            if (done != '0) begin
                if (!cur_valid) begin
                    check("unexpected_done", int'(done), 0);
                end else begin
                    check("done_vec", int'(done), 1 << cur.id);
                    check("done_grant", int'(grant), 1 << cur.id);
                    check("done_latency", cyc - load_cyc, cur.lat);
                    check("done_not_aborted", int'(cur.abort), 0);
                    saw_done      = 1'b1;
                    last_done_cyc = cyc;
                end
            end
            if (prev_grant != '0 && grant == '0 && cur_valid) begin
                check("release_done_seen", int'(saw_done), int'(!cur.abort));
                check("release_busy", int'(busy), 0);
                check("release_active_id", int'(active_id), 0);
                cur_valid = 1'b0;
            end
            prev_grant = grant;
            prev_load  = cnt_load;
        end
    end

    initial begin
        rst       = 1'b0;
        req       = '0;
        req_start = '0;
        req_limit = '0;
        repeat (2) @(negedge clk);
        check("rst_grant", int'(grant), 0);
        check("rst_done", int'(done), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_active_id", int'(active_id), 0);
        check("rst_cnt_load", int'(cnt_load), 0);
        check("rst_cnt_data", int'(cnt_data), 0);
        rst = 1'b1;
        @(negedge clk);

        // All four held, limit = start+1: order 0,1,2,3,0 with one idle cycle between.
        for (int i = 0; i < NREQ; i++) set_vals(i, 30 + 10 * i, 31 + 10 * i);
        push(0, 30, 3, 1'b0, 1'b0);
        push(1, 40, 3, 1'b0, 1'b1);
        push(2, 50, 3, 1'b0, 1'b1);
        push(3, 60, 3, 1'b0, 1'b1);
        push(0, 30, 3, 1'b0, 1'b1);
        req = 4'b1111;
        wait_done(0);
        wait_done(1); req[1] = 1'b0;
        wait_done(2); req[2] = 1'b0;
        wait_done(3); req[3] = 1'b0;
        wait_done(0); req[0] = 1'b0;
        repeat (2) @(negedge clk);

        // Basic service: 10 -> 13.
        set_vals(0, 10, 13);
        push(0, 10, 5, 1'b0, 1'b0);
        req = 4'b0001;
        wait_done(0); req[0] = 1'b0;
        repeat (2) @(negedge clk);

        // Abort requester 1 mid-run; 3 must win next, then 0.
        set_vals(1, 0, 200);
        set_vals(3, 5, 7);
        set_vals(0, 20, 20);
        push(1, 0, 0, 1'b1, 1'b0);
        push(3, 5, 4, 1'b0, 1'b0);
        push(0, 20, 2, 1'b0, 1'b1);
        req = 4'b1011;
        repeat (8) @(negedge clk);
        req[1] = 1'b0;
        wait_done(3); req[3] = 1'b0;
        wait_done(0); req[0] = 1'b0;
        repeat (2) @(negedge clk);

        // Wrap 250 -> 2, then start == limit.
        set_vals(3, 250, 2);
        push(3, 250, 10, 1'b0, 1'b0);
        req = 4'b1000;
        wait_done(3); req[3] = 1'b0;
        repeat (2) @(negedge clk);
        set_vals(2, 77, 77);
        push(2, 77, 2, 1'b0, 1'b0);
        req = 4'b0100;
        wait_done(2); req[2] = 1'b0;
        repeat (2) @(negedge clk);

        // Asynchronous reset during RUN.
        set_vals(1, 0, 100);
        push(1, 0, 0, 1'b1, 1'b0);
        req = 4'b0010;
        repeat (6) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("async_rst_grant", int'(grant), 0);
        check("async_rst_done", int'(done), 0);
        check("async_rst_cnt_load", int'(cnt_load), 0);
        check("async_rst_busy", int'(busy), 0);
        check("async_rst_active_id", int'(active_id), 0);
        @(negedge clk);
        sb.delete();
        req = '0;
        #2 rst = 1'b1;
        @(negedge clk);

        // rr_ptr back at 0: with 1 and 3 pending, 1 goes first.
        set_vals(1, 3, 4);
        set_vals(3, 9, 9);
        push(1, 3, 3, 1'b0, 1'b0);
        push(3, 9, 2, 1'b0, 1'b1);
        req = 4'b1010;
        wait_done(1); req[1] = 1'b0;
        wait_done(3); req[3] = 1'b0;
        repeat (2) @(negedge clk);
        set_vals(2, 40, 42);
        push(2, 40, 4, 1'b0, 1'b0);
        req = 4'b0100;
        wait_done(2); req[2] = 1'b0;
        repeat (3) @(negedge clk);

        check("scoreboard_empty", sb.size(), 0);
        check("final_busy", int'(busy), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
